// File: rtl/encode_mbuf.sv
// MBUF instruction encoder: buffers MUBUF/MTBUF instructions in a small FIFO and
// emits each one as two 32-bit dwords (dword0 then dword1) under a stall handshake.

package common_pkg;
    typedef struct packed {
        logic        is_mtbuf;
        logic [7:0]  op;
        logic [6:0]  dfmt;
        logic        lds;
        logic        dlc;
        logic        glc;
        logic        idxen;
        logic        offen;
        logic [11:0] offset;
        logic [7:0]  vaddr;
        logic [7:0]  vdata;
        logic [4:0]  srsrc;
        logic        slc;
        logic        tfe;
        logic [7:0]  soffset;
    } mbuf_inst_t;
endpackage

// state | meaning
// IDLE  | nothing presented; pops FIFO head when count>0 and not stalled
// DW0   | dword0 presented on word_out, dword1 held in side register
// DW1   | dword1 presented; on consume chains straight into next dword0 if available
module encode_mbuf
    import common_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  mbuf_inst_t       in_inst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    output logic [31:0]      word_out,
    output logic             word_valid,
    output logic             word_last,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, DW0, DW1} state_t;

    state_t            state_q, state_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       side_q, side_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       mem_dw0_q [DEPTH];
    logic [31:0]       mem_dw1_q [DEPTH];
    logic              push, pop;

    function automatic logic [31:0] enc_dw0(input mbuf_inst_t i);
        logic [31:0] w;
        w[15:0] = {i.dlc, i.glc, i.idxen, i.offen, i.offset};
        if (i.is_mtbuf)
            w[31:16] = {6'b111010, i.dfmt, i.op[2:0]};
        else
            w[31:16] = {6'b111000, i.op, 1'b0, i.lds};
        return w;
    endfunction

    function automatic logic [31:0] enc_dw1(input mbuf_inst_t i);
        logic bit21;
        bit21 = i.is_mtbuf ? 1'b0 : i.op[3];
        return {i.soffset, i.tfe, i.slc, bit21, i.srsrc, i.vdata, i.vaddr};
    endfunction

    assign in_ready   = (count_q < FULL);
    assign push       = in_valid & in_ready;
    assign word_out   = word_q;
    assign word_valid = (state_q != IDLE);
    assign word_last  = (state_q == DW1);
    assign count      = count_q;
    assign busy       = (count_q != '0) | word_valid;

    // Entries are encoded at push so later in_inst changes cannot leak in.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dw0_q[wr_ptr_q] <= enc_dw0(in_inst);
            mem_dw1_q[wr_ptr_q] <= enc_dw1(in_inst);
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        side_d  = side_q;
        pop     = 1'b0;
        if (!stall) begin
            unique case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        word_d  = mem_dw0_q[rd_ptr_q];
                        side_d  = mem_dw1_q[rd_ptr_q];
                        state_d = DW0;
                    end
                end
                DW0: begin
                    word_d  = side_q;
                    state_d = DW1;
                end
                DW1: begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        word_d  = mem_dw0_q[rd_ptr_q];
                        side_d  = mem_dw1_q[rd_ptr_q];
                        state_d = DW0;
                    end else begin
                        word_d  = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            word_q   <= '0;
            side_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            side_q  <= side_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_encode_mbuf.sv
// Directed bench for encode_mbuf: hand-computed dword encodings, handshake,
// stall, full-FIFO and asynchronous-reset behaviour.

module tb_encode_mbuf;
    import common_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    mbuf_inst_t       in_inst;
    logic             in_valid;
    logic             in_ready;
    logic             stall;
    logic [31:0]      word_out;
    logic             word_valid;
    logic             word_last;
    logic [CNT_W-1:0] count;
    logic             busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    encode_mbuf #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_inst   (in_inst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stall     (stall),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_last (word_last),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] exp_w, input logic exp_last);
        chk({tag, ".valid"}, {31'd0, word_valid}, 32'd1);
        chk({tag, ".word"},  word_out, exp_w);
        chk({tag, ".last"},  {31'd0, word_last}, {31'd0, exp_last});
    endtask

    // MUBUF with op=k and vaddr=k: dword0 = E0000000 | k<<18, dword1 = k (k < 8)
    function automatic mbuf_inst_t mk(input int k);
        mbuf_inst_t i;
        i       = '0;
        i.op    = 8'(k);
        i.vaddr = 8'(k);
        return i;
    endfunction

    function automatic logic [31:0] mk_dw0(input int k);
        return 32'hE000_0000 | (32'(k) << 18);
    endfunction

    mbuf_inst_t ia, ib, ic;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        stall    = 1'b0;
        in_inst  = '0;
        #1;
        chk("rst.valid", {31'd0, word_valid}, 32'd0);
        chk("rst.ready", {31'd0, in_ready}, 32'd1);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.busy",  {31'd0, busy}, 32'd0);
        chk("rst.word",  word_out, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // single MUBUF
        ia = '0;
        ia.op = 8'h14; ia.offset = 12'h123; ia.offen = 1'b1; ia.glc = 1'b1;
        ia.vaddr = 8'h02; ia.vdata = 8'h05; ia.srsrc = 5'h04; ia.soffset = 8'h80;
        in_inst = ia; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_inst = '0;
        chk("mubuf.count_after_push", 32'(count), 32'd1);
        chk("mubuf.not_yet_valid", {31'd0, word_valid}, 32'd0);
        step();
        chk_word("mubuf.dw0", 32'hE050_5123, 1'b0);
        chk("mubuf.count_pop", 32'(count), 32'd0);
        step();
        chk_word("mubuf.dw1", 32'h8004_0502, 1'b1);
        step();
        chk("mubuf.idle_valid", {31'd0, word_valid}, 32'd0);
        chk("mubuf.idle_busy", {31'd0, busy}, 32'd0);

        // single MTBUF
        ib = '0;
        ib.is_mtbuf = 1'b1; ib.op = 8'h05; ib.dfmt = 7'h4A; ib.offset = 12'hFFF;
        ib.idxen = 1'b1; ib.dlc = 1'b1; ib.vaddr = 8'h10; ib.vdata = 8'h20;
        ib.srsrc = 5'h1F; ib.slc = 1'b1; ib.tfe = 1'b1; ib.soffset = 8'h7C;
        in_inst = ib; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk_word("mtbuf.dw0", 32'hEA55_AFFF, 1'b0);
        step();
        chk_word("mtbuf.dw1", 32'h7CDF_2010, 1'b1);
        step();
        chk("mtbuf.idle_valid", {31'd0, word_valid}, 32'd0);

        // back-to-back: three pushes on consecutive edges
        ic = '0;
        ic.op = 8'h0F; ic.lds = 1'b1; ic.vaddr = 8'hAA; ic.vdata = 8'h55; ic.soffset = 8'h01;
        in_inst = ia; in_valid = 1'b1;
        step();
        in_inst = ib;
        step();
        chk_word("b2b.a0", 32'hE050_5123, 1'b0);
        chk("b2b.count1", 32'(count), 32'd1);
        in_inst = ic;
        step();
        in_valid = 1'b0; in_inst = '0;
        chk_word("b2b.a1", 32'h8004_0502, 1'b1);
        chk("b2b.count_peak", 32'(count), 32'd2);
        step();
        chk_word("b2b.b0", 32'hEA55_AFFF, 1'b0);
        step();
        chk_word("b2b.b1", 32'h7CDF_2010, 1'b1);
        step();
        chk_word("b2b.c0", 32'hE03D_0000, 1'b0);
        step();
        chk_word("b2b.c1", 32'h0120_55AA, 1'b1);
        step();
        chk("b2b.idle", {31'd0, word_valid}, 32'd0);

        // stall + full FIFO
        in_inst = mk(1); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk_word("full.first", mk_dw0(1), 1'b0);
        stall = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            in_inst = mk(k); in_valid = 1'b1;
            chk($sformatf("full.ready%0d", k), {31'd0, in_ready}, (k <= 5) ? 32'd1 : 32'd0);
            step();
            chk($sformatf("full.count%0d", k), 32'(count), (k <= 5) ? 32'(k - 1) : 32'd4);
            chk_word($sformatf("full.frozen%0d", k), mk_dw0(1), 1'b0);
        end
        in_valid = 1'b0;
        chk("full.ready_low", {31'd0, in_ready}, 32'd0);
        stall = 1'b0;
        step();
        chk_word("full.dw1_1", 32'd1, 1'b1);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk_word($sformatf("full.dw0_%0d", k), mk_dw0(k), 1'b0);
            step();
            chk_word($sformatf("full.dw1_%0d", k), 32'(k), 1'b1);
        end
        step();
        chk("full.drained", {31'd0, word_valid}, 32'd0);
        chk("full.count0", 32'(count), 32'd0);

        // stall while dword1 is presented
        in_inst = mk(2); in_valid = 1'b1;
        step();
        in_inst = mk(3);
        step();
        in_valid = 1'b0;
        step();
        chk_word("sdw1.presented", 32'd2, 1'b1);
        stall = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            chk_word($sformatf("sdw1.hold%0d", n), 32'd2, 1'b1);
            chk($sformatf("sdw1.count%0d", n), 32'(count), 32'd1);
        end
        stall = 1'b0;
        step();
        chk_word("sdw1.next", mk_dw0(3), 1'b0);
        chk("sdw1.count_after", 32'(count), 32'd0);
        step();
        chk_word("sdw1.next1", 32'd3, 1'b1);
        step();
        chk("sdw1.idle", {31'd0, word_valid}, 32'd0);

        // async reset while DW1 presented with count=2
        in_inst = mk(1); in_valid = 1'b1;
        step();
        in_inst = mk(2);
        step();
        in_inst = mk(3);
        step();
        in_valid = 1'b0;
        chk_word("arst.pre", 32'd1, 1'b1);
        chk("arst.pre_count", 32'(count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.valid", {31'd0, word_valid}, 32'd0);
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.ready", {31'd0, in_ready}, 32'd1);
        chk("arst.busy",  {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            chk($sformatf("arst.nostale%0d", n), {31'd0, word_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
